// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: a one-entry pipeline register in front of the ALU.
// It resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and holds its entry under back-pressure.
module ex_operand_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [XLEN-1:0] id_pc,
    input  logic [RA_W-1:0] id_rs1_addr,
    input  logic [RA_W-1:0] id_rs2_addr,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_use_pc,
    input  logic            id_use_imm,
    input  logic [2:0]      id_alu_sel,
    input  logic            id_func7,
    input  logic [RA_W-1:0] id_rd_addr,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            exm_wen,
    input  logic [RA_W-1:0] exm_rd,
    input  logic [XLEN-1:0] exm_data,
    input  logic            mwb_wen,
    input  logic [RA_W-1:0] mwb_rd,
    input  logic [XLEN-1:0] mwb_data,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [2:0]      ex_alu_sel,
    output logic            ex_func7,
    output logic [XLEN-1:0] ex_op1,
    output logic [XLEN-1:0] ex_op2,
    output logic [XLEN-1:0] ex_store_data,
    output logic [XLEN-1:0] ex_pc,
    output logic [RA_W-1:0] ex_rd_addr,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [RA_W-1:0] rs1_addr_q, rs1_addr_d;
    logic [RA_W-1:0] rs2_addr_q, rs2_addr_d;
    logic [XLEN-1:0] rs1_val_q, rs1_val_d;
    logic [XLEN-1:0] rs2_val_q, rs2_val_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic            use_pc_q, use_pc_d;
    logic            use_imm_q, use_imm_d;
    logic [2:0]      alu_sel_q, alu_sel_d;
    logic            func7_q, func7_d;
    logic [RA_W-1:0] rd_addr_q, rd_addr_d;
    logic            reg_write_q, reg_write_d;
    logic            mem_read_q, mem_read_d;
    logic            mem_write_q, mem_write_d;

    logic            accept_s;
    logic            issue_s;
    logic [XLEN-1:0] fwd_rs1_s;
    logic [XLEN-1:0] fwd_rs2_s;

    // A bypass source hits only when it writes the same, non-x0 register.
    function automatic logic bypass_hit(input logic wen, input logic [RA_W-1:0] rd,
                                        input logic [RA_W-1:0] rs);
        return wen && (rd == rs) && (rs != {RA_W{1'b0}});
    endfunction

    // EX/MEM wins over MEM/WB, which wins over the stored value; x0 always reads as 0.
    function automatic logic [XLEN-1:0] fwd_value(
        input logic [RA_W-1:0] rs, input logic [XLEN-1:0] stored,
        input logic e_wen, input logic [RA_W-1:0] e_rd, input logic [XLEN-1:0] e_data,
        input logic m_wen, input logic [RA_W-1:0] m_rd, input logic [XLEN-1:0] m_data);
        logic [XLEN-1:0] v;
        if (rs == {RA_W{1'b0}}) begin
            v = {XLEN{1'b0}};
        end else if (bypass_hit(e_wen, e_rd, rs)) begin
            v = e_data;
        end else if (bypass_hit(m_wen, m_rd, rs)) begin
            v = m_data;
        end else begin
            v = stored;
        end
        return v;
    endfunction

    // Handshakes; id_ready is held low during reset and never depends on operand data.
    always_comb begin
        id_ready = rst_n && !flush && (!valid_q || ex_ready);
        accept_s = id_valid && id_ready;
        issue_s  = valid_q && ex_ready;
    end

    // Next-state: capture on accept, otherwise keep fields and absorb MEM/WB writes into the stored operands.
    always_comb begin
        pc_d        = pc_q;
        rs1_addr_d  = rs1_addr_q;
        rs2_addr_d  = rs2_addr_q;
        rs1_val_d   = rs1_val_q;
        rs2_val_d   = rs2_val_q;
        imm_d       = imm_q;
        use_pc_d    = use_pc_q;
        use_imm_d   = use_imm_q;
        alu_sel_d   = alu_sel_q;
        func7_d     = func7_q;
        rd_addr_d   = rd_addr_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;

        if (flush) begin
            valid_d = 1'b0;
        end else if (accept_s) begin
            valid_d = 1'b1;
        end else if (issue_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        if (accept_s) begin
            pc_d        = id_pc;
            rs1_addr_d  = id_rs1_addr;
            rs2_addr_d  = id_rs2_addr;
            imm_d       = id_imm;
            use_pc_d    = id_use_pc;
            use_imm_d   = id_use_imm;
            alu_sel_d   = id_alu_sel;
            func7_d     = id_func7;
            rd_addr_d   = id_rd_addr;
            reg_write_d = id_reg_write;
            mem_read_d  = id_mem_read;
            mem_write_d = id_mem_write;
            if (bypass_hit(mwb_wen, mwb_rd, id_rs1_addr)) begin
                rs1_val_d = mwb_data;
            end else begin
                rs1_val_d = id_rs1_data;
            end
            if (bypass_hit(mwb_wen, mwb_rd, id_rs2_addr)) begin
                rs2_val_d = mwb_data;
            end else begin
                rs2_val_d = id_rs2_data;
            end
        end else begin
            // A producer retiring while this entry stalls must not be lost.
            if (bypass_hit(mwb_wen, mwb_rd, rs1_addr_q)) begin
                rs1_val_d = mwb_data;
            end else begin
                rs1_val_d = rs1_val_q;
            end
            if (bypass_hit(mwb_wen, mwb_rd, rs2_addr_q)) begin
                rs2_val_d = mwb_data;
            end else begin
                rs2_val_d = rs2_val_q;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            pc_q        <= {XLEN{1'b0}};
            rs1_addr_q  <= {RA_W{1'b0}};
            rs2_addr_q  <= {RA_W{1'b0}};
            rs1_val_q   <= {XLEN{1'b0}};
            rs2_val_q   <= {XLEN{1'b0}};
            imm_q       <= {XLEN{1'b0}};
            use_pc_q    <= 1'b0;
            use_imm_q   <= 1'b0;
            alu_sel_q   <= 3'b000;
            func7_q     <= 1'b0;
            rd_addr_q   <= {RA_W{1'b0}};
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            rs1_addr_q  <= rs1_addr_d;
            rs2_addr_q  <= rs2_addr_d;
            rs1_val_q   <= rs1_val_d;
            rs2_val_q   <= rs2_val_d;
            imm_q       <= imm_d;
            use_pc_q    <= use_pc_d;
            use_imm_q   <= use_imm_d;
            alu_sel_q   <= alu_sel_d;
            func7_q     <= func7_d;
            rd_addr_q   <= rd_addr_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    // Forwarded operands and ALU input selection.
    always_comb begin
        fwd_rs1_s = fwd_value(rs1_addr_q, rs1_val_q, exm_wen, exm_rd, exm_data,
                              mwb_wen, mwb_rd, mwb_data);
        fwd_rs2_s = fwd_value(rs2_addr_q, rs2_val_q, exm_wen, exm_rd, exm_data,
                              mwb_wen, mwb_rd, mwb_data);
        if (use_pc_q) begin
            ex_op1 = pc_q;
        end else begin
            ex_op1 = fwd_rs1_s;
        end
        if (use_imm_q) begin
            ex_op2 = imm_q;
        end else begin
            ex_op2 = fwd_rs2_s;
        end
        ex_store_data = fwd_rs2_s;
    end

    assign ex_valid     = valid_q;
    assign ex_alu_sel   = alu_sel_q;
    assign ex_func7     = func7_q;
    assign ex_pc        = pc_q;
    assign ex_rd_addr   = rd_addr_q;
    assign ex_reg_write = reg_write_q;
    assign ex_mem_read  = mem_read_q;
    assign ex_mem_write = mem_write_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: directed entries push expected ALU inputs;
// a negedge monitor pops and compares on every issue handshake.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n, flush, id_valid, id_ready;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic        id_use_pc, id_use_imm, id_func7, id_reg_write, id_mem_read, id_mem_write;
    logic [2:0]  id_alu_sel;
    logic        exm_wen, mwb_wen;
    logic [4:0]  exm_rd, mwb_rd;
    logic [31:0] exm_data, mwb_data;
    logic        ex_valid, ex_ready, ex_func7, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [2:0]  ex_alu_sel;
    logic [31:0] ex_op1, ex_op2, ex_store_data, ex_pc;
    logic [4:0]  ex_rd_addr;

    typedef struct packed {
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1a, rs2a, rd;
        logic        use_pc, use_imm;
        logic [2:0]  alu;
        logic        f7, rw, mr, mw;
    } item_t;

    typedef struct packed {
        logic [31:0] op1, op2, st, pc;
        logic [11:0] side;
    } exp_t;

    exp_t sb_q[$];
    int   vec_cnt  = 0;
    int   miss_cnt = 0;

    ex_operand_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_use_pc(id_use_pc), .id_use_imm(id_use_imm), .id_alu_sel(id_alu_sel),
        .id_func7(id_func7), .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .exm_wen(exm_wen), .exm_rd(exm_rd), .exm_data(exm_data),
        .mwb_wen(mwb_wen), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alu_sel(ex_alu_sel), .ex_func7(ex_func7),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_store_data(ex_store_data), .ex_pc(ex_pc),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        vec_cnt++;
        if (act !== exp_v) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    function automatic item_t mk_item(input logic [31:0] pc, input logic [4:0] rs1a,
        input logic [31:0] rs1d, input logic [4:0] rs2a, input logic [31:0] rs2d,
        input logic [31:0] imm, input logic use_pc, input logic use_imm, input logic [2:0] alu,
        input logic f7, input logic [4:0] rd, input logic rw, input logic mr, input logic mw);
        item_t it;
        it.pc = pc; it.rs1a = rs1a; it.rs1d = rs1d; it.rs2a = rs2a; it.rs2d = rs2d;
        it.imm = imm; it.use_pc = use_pc; it.use_imm = use_imm; it.alu = alu; it.f7 = f7;
        it.rd = rd; it.rw = rw; it.mr = mr; it.mw = mw;
        return it;
    endfunction

    function automatic void push_exp(input item_t it, input logic [31:0] op1,
                                     input logic [31:0] op2, input logic [31:0] st);
        exp_t e;
        e.op1 = op1; e.op2 = op2; e.st = st; e.pc = it.pc;
        e.side = {it.rd, it.alu, it.f7, it.rw, it.mr, it.mw};
        sb_q.push_back(e);
    endfunction

    task automatic apply(input item_t it);
        id_pc = it.pc; id_rs1_addr = it.rs1a; id_rs1_data = it.rs1d;
        id_rs2_addr = it.rs2a; id_rs2_data = it.rs2d; id_imm = it.imm;
        id_use_pc = it.use_pc; id_use_imm = it.use_imm; id_alu_sel = it.alu;
        id_func7 = it.f7; id_rd_addr = it.rd; id_reg_write = it.rw;
        id_mem_read = it.mr; id_mem_write = it.mw;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input item_t it);
        apply(it);
        id_valid = 1'b1;
        tick();
        id_valid = 1'b0;
    endtask

    // Monitor: every issue handshake must match the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ex_valid && ex_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_issue", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("op1", ex_op1, e.op1);
                check("op2", ex_op2, e.op2);
                check("store_data", ex_store_data, e.st);
                check("pc", ex_pc, e.pc);
                check("sideband", {20'd0, ex_rd_addr, ex_alu_sel, ex_func7, ex_reg_write,
                                   ex_mem_read, ex_mem_write}, {20'd0, e.side});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        item_t it;
        rst_n = 1'b0; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b0;
        apply(mk_item(32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 3'b000,
                      1'b0, 5'd0, 1'b0, 1'b0, 1'b0));
        exm_wen = 1'b0; exm_rd = 5'd0; exm_data = 32'd0;
        mwb_wen = 1'b0; mwb_rd = 5'd0; mwb_data = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_id_ready", 32'(id_ready), 32'd0);
        check("rst_ex_valid", 32'(ex_valid), 32'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_id_ready", 32'(id_ready), 32'd1);

        // Plain ADD, no hazards
        ex_ready = 1'b1;
        it = mk_item(32'h100, 5'd5, 32'd7, 5'd6, 32'd3, 32'd0, 1'b0, 1'b0, 3'b000,
                     1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        push_exp(it, 32'd7, 32'd3, 32'd3);
        send(it);
        tick();

        // Forwarding priority during a hold
        ex_ready = 1'b0;
        it = mk_item(32'h104, 5'd5, 32'd7, 5'd6, 32'd3, 32'h10, 1'b0, 1'b1, 3'b010,
                     1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        push_exp(it, 32'd30, 32'h10, 32'd3);
        send(it);
        exm_wen = 1'b1; exm_rd = 5'd5; exm_data = 32'd20;
        mwb_wen = 1'b1; mwb_rd = 5'd5; mwb_data = 32'd30;
        @(negedge clk);
        check("fwd_exm_priority", ex_op1, 32'd20);
        tick();
        exm_wen = 1'b0;
        ex_ready = 1'b1;
        @(negedge clk);
        check("fwd_mwb_fallback", ex_op1, 32'd30);
        tick();
        mwb_wen = 1'b0; ex_ready = 1'b0;

        // MEM/WB write captured while stalled
        it = mk_item(32'h108, 5'd1, 32'h11, 5'd6, 32'd3, 32'd0, 1'b0, 1'b0, 3'b000,
                     1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        push_exp(it, 32'h11, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        send(it);
        tick();
        mwb_wen = 1'b1; mwb_rd = 5'd6; mwb_data = 32'hDEAD_BEEF;
        tick();
        mwb_wen = 1'b0; mwb_data = 32'd0;
        @(negedge clk);
        check("stall_capture_op2", ex_op2, 32'hDEAD_BEEF);
        check("stall_capture_store", ex_store_data, 32'hDEAD_BEEF);
        check("stall_hold_valid", 32'(ex_valid), 32'd1);
        tick();
        ex_ready = 1'b1;
        tick();

        // x0 is never forwarded; then PC/immediate operand select
        exm_wen = 1'b1; exm_rd = 5'd0; exm_data = 32'hFFFF_FFFF;
        mwb_wen = 1'b1; mwb_rd = 5'd0; mwb_data = 32'h1234;
        it = mk_item(32'h10C, 5'd0, 32'h55, 5'd0, 32'h66, 32'd0, 1'b0, 1'b0, 3'b111,
                     1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
        push_exp(it, 32'd0, 32'd0, 32'd0);
        send(it);
        @(negedge clk);
        check("x0_guard_op1", ex_op1, 32'd0);
        #4;
        it = mk_item(32'h2000, 5'd3, 32'h77, 5'd6, 32'h99, 32'hFFFF_FFF0, 1'b1, 1'b1, 3'b000,
                     1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        push_exp(it, 32'h2000, 32'hFFFF_FFF0, 32'h99);
        send(it);
        tick();
        exm_wen = 1'b0; mwb_wen = 1'b0;

        // Flush against a simultaneous issue and accept
        it = mk_item(32'h200, 5'd2, 32'hA, 5'd3, 32'hB, 32'd0, 1'b0, 1'b0, 3'b100,
                     1'b0, 5'd11, 1'b1, 1'b0, 1'b0);
        push_exp(it, 32'hA, 32'hB, 32'hB);
        send(it);
        apply(mk_item(32'h204, 5'd4, 32'hC, 5'd4, 32'hD, 32'd0, 1'b0, 1'b0, 3'b001,
                      1'b0, 5'd12, 1'b1, 1'b0, 1'b0));
        id_valid = 1'b1; flush = 1'b1;
        #1;
        check("flush_id_ready", 32'(id_ready), 32'd0);
        tick();
        flush = 1'b0; id_valid = 1'b0;
        @(negedge clk);
        check("flush_ex_valid", 32'(ex_valid), 32'd0);
        tick();

        // Flush of a held entry
        ex_ready = 1'b0;
        send(mk_item(32'h208, 5'd4, 32'hE, 5'd4, 32'hE, 32'd0, 1'b0, 1'b0, 3'b001,
                     1'b0, 5'd13, 1'b1, 1'b0, 1'b0));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("flush_hold_ex_valid", 32'(ex_valid), 32'd0);
        ex_ready = 1'b1;
        tick();

        // Back-to-back accepts: one issue per cycle, no bubbles
        for (int i = 0; i < 4; i++) begin
            it = mk_item(32'h300 + 32'(4 * i), 5'd5, 32'd100 + 32'(i), 5'd6, 32'd200 + 32'(i),
                         32'd0, 1'b0, 1'b0, 3'b001, 1'b0, 5'd14 + 5'(i), 1'b1, 1'b0, 1'b0);
            push_exp(it, 32'd100 + 32'(i), 32'd200 + 32'(i), 32'd200 + 32'(i));
            apply(it);
            id_valid = 1'b1;
            #1;
            check("b2b_id_ready", 32'(id_ready), 32'd1);
            tick();
            check("b2b_ex_valid", 32'(ex_valid), 32'd1);
        end
        id_valid = 1'b0;
        for (int n = 0; n < 20 && sb_q.size() != 0; n++) tick();
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        // Asynchronous reset while holding an entry
        ex_ready = 1'b0;
        send(mk_item(32'h400, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0, 3'b000,
                     1'b0, 5'd1, 1'b1, 1'b0, 1'b0));
        @(negedge clk);
        check("pre_reset_op1", ex_op1, 32'h400);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_ex_valid", 32'(ex_valid), 32'd0);
        check("async_rst_op1", ex_op1, 32'd0);
        check("async_rst_id_ready", 32'(id_ready), 32'd0);
        tick();
        check("in_rst_id_ready", 32'(id_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_release_id_ready", 32'(id_ready), 32'd1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
